// File: rtl/exe_ctrl_pkg.sv
// Shared types and constants for the execution-unit arbiter and its clients.
package exe_ctrl_pkg;

    localparam int unsigned STAT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } exe_ctrl_state_t;

    localparam logic [1:0] OP_0 = 2'b00;
    localparam logic [1:0] OP_1 = 2'b01;
    localparam logic [1:0] OP_2 = 2'b10;
    localparam logic [1:0] OP_3 = 2'b11;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid requester at or after the pointer, wrapping.
module rr_pick #(
    parameter int unsigned REQ  = 4,
    parameter int unsigned ID_W = $clog2(REQ)
) (
    input  logic [REQ-1:0]  i_valid,
    input  logic [ID_W-1:0] i_ptr,
    output logic [REQ-1:0]  o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    logic [ID_W-1:0] w_k;

    // Scan from farthest to nearest so the nearest valid index wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_k     = '0;
        for (int i = int'(REQ) - 1; i >= 0; i--) begin
            w_k = ID_W'((32'(i_ptr) + 32'(i)) % REQ);
            if (i_valid[w_k]) begin
                o_grant      = '0;
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exe_unit_arbiter.sv
// Round-robin sequencer sharing one execution unit among REQ requesters.
module exe_unit_arbiter
    import exe_ctrl_pkg::*;
#(
    parameter int unsigned M    = 4,
    parameter int unsigned N    = 2,
    parameter int unsigned REQ  = 4,
    parameter int unsigned ID_W = $clog2(REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [REQ-1:0]          i_req_valid,
    input  logic [REQ-1:0][N-1:0]   i_req_oper,
    input  logic [REQ-1:0][M-1:0]   i_req_argA,
    input  logic [REQ-1:0][M-1:0]   i_req_argB,
    output logic [REQ-1:0]          o_req_ready,
    output logic [N-1:0]            o_exe_oper,
    output logic [M-1:0]            o_exe_argA,
    output logic [M-1:0]            o_exe_argB,
    input  logic [M-1:0]            i_exe_result,
    input  logic [STAT_W-1:0]       i_exe_status,
    output logic                    o_rsp_valid,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [M-1:0]            o_rsp_result,
    output logic [STAT_W-1:0]       o_rsp_status,
    input  logic                    i_rsp_ready,
    output logic                    o_busy
);

    exe_ctrl_state_t r_state, w_next_state;

    logic [ID_W-1:0]   r_ptr, r_gid, w_gidx;
    logic [REQ-1:0]    w_grant;
    logic              w_any, w_accept, w_capture, w_release;
    logic [N-1:0]      r_exe_oper;
    logic [M-1:0]      r_exe_argA, r_exe_argB, r_rsp_result;
    logic [STAT_W-1:0] r_rsp_status;
    logic [ID_W-1:0]   r_rsp_id;
    logic              r_rsp_valid, r_busy;

    rr_pick #(.REQ(REQ), .ID_W(ID_W)) u_pick (
        .i_valid (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Grant is only offered in IDLE and never while reset is asserted.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        o_req_ready  = '0;
        case (r_state)
            IDLE: begin
                if (w_any && !i_rst) begin
                    o_req_ready  = w_grant;
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: w_next_state = CAPT;
            CAPT: begin
                w_capture    = 1'b1;
                w_next_state = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    w_release    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr        <= '0;
            r_gid        <= '0;
            r_exe_oper   <= '0;
            r_exe_argA   <= '0;
            r_exe_argB   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_status <= '0;
            r_busy       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_exe_oper <= i_req_oper[w_gidx];
                r_exe_argA <= i_req_argA[w_gidx];
                r_exe_argB <= i_req_argB[w_gidx];
                r_gid      <= w_gidx;
                r_ptr      <= (w_gidx == ID_W'(REQ - 1)) ? '0 : w_gidx + ID_W'(1);
            end
            if (w_capture) begin
                r_rsp_result <= i_exe_result;
                r_rsp_status <= i_exe_status;
                r_rsp_id     <= r_gid;
                r_rsp_valid  <= 1'b1;
            end
            if (w_release) r_rsp_valid <= 1'b0;
            r_busy <= (w_next_state != IDLE);
        end
    end

    assign o_exe_oper   = r_exe_oper;
    assign o_exe_argA   = r_exe_argA;
    assign o_exe_argB   = r_exe_argB;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_status = r_rsp_status;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_exe_unit_arbiter.sv
// Bench for exe_unit_arbiter with an XOR execution-unit stub and a transaction-level model.
module tb_exe_unit_arbiter;
    import exe_ctrl_pkg::*;

    localparam int unsigned M    = 4;
    localparam int unsigned N    = 2;
    localparam int unsigned REQ  = 4;
    localparam int unsigned ID_W = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [REQ-1:0]        req_valid;
    logic [REQ-1:0][N-1:0] req_oper;
    logic [REQ-1:0][M-1:0] req_a, req_b;
    logic [REQ-1:0]        req_ready;
    logic [N-1:0]          exe_oper;
    logic [M-1:0]          exe_a, exe_b, stub_res, rsp_result;
    logic [3:0]            stub_stat, rsp_status;
    logic                  rsp_valid, rsp_ready, busy;
    logic [ID_W-1:0]       rsp_id;

    always #5 clk = ~clk;

    exe_unit_arbiter #(.M(M), .N(N), .REQ(REQ), .ID_W(ID_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .i_req_oper   (req_oper),
        .i_req_argA   (req_a),
        .i_req_argB   (req_b),
        .o_req_ready  (req_ready),
        .o_exe_oper   (exe_oper),
        .o_exe_argA   (exe_a),
        .o_exe_argB   (exe_b),
        .i_exe_result (stub_res),
        .i_exe_status (stub_stat),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .o_rsp_status (rsp_status),
        .i_rsp_ready  (rsp_ready),
        .o_busy       (busy)
    );

    // One-cycle registered execution-unit stub.
    always @(posedge clk) begin
        stub_res  <= exe_a ^ exe_b;
        stub_stat <= {exe_oper, 2'b01};
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rv_cycles = 0;
    int grant_log[$];
    int rsp_ids[$];
    int rsp_cycles[$];
    logic [REQ-1:0] last_ready = '0;
    logic hold = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [REQ-1:0] v, input int p);
        for (int k = 0; k < int'(REQ); k++) begin
            if (v[(p + k) % int'(REQ)]) return (p + k) % int'(REQ);
        end
        return -1;
    endfunction

    // Transaction-level model: phase counts cycles since accept; 3 means a response is pending.
    int              m_phase = 0;
    int              m_ptr   = 0;
    int              m_gid   = 0;
    logic [N-1:0]    m_oper  = '0;
    logic [M-1:0]    m_a = '0, m_b = '0, m_res = '0;
    logic [3:0]      m_stat  = '0;
    logic [ID_W-1:0] m_rid   = '0;
    logic            m_rvalid = 1'b0;

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_gid = 0;
            m_oper = '0; m_a = '0; m_b = '0;
            m_res = '0; m_stat = '0; m_rid = '0; m_rvalid = 1'b0;
        end else if (m_phase == 0) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) begin
                m_gid  = g;
                m_oper = req_oper[g];
                m_a    = req_a[g];
                m_b    = req_b[g];
                m_ptr  = (g + 1) % int'(REQ);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_res    = m_a ^ m_b;
            m_stat   = {m_oper, 2'b01};
            m_rid    = ID_W'(m_gid);
            m_rvalid = 1'b1;
            m_phase  = 3;
        end else if (rsp_ready) begin
            m_rvalid = 1'b0;
            m_phase  = 0;
        end
    end

    // Compare every cycle on the falling edge, and log grants/responses.
    always @(negedge clk) begin
        logic [REQ-1:0] er;
        int g;
        er = '0;
        g = pick(req_valid, m_ptr);
        if (m_phase == 0 && !rst && g >= 0) er[g] = 1'b1;
        chk("ready",      32'(req_ready),  32'(er));
        chk("busy",       32'(busy),       32'(m_phase != 0));
        chk("rsp_valid",  32'(rsp_valid),  32'(m_rvalid));
        chk("rsp_id",     32'(rsp_id),     32'(m_rid));
        chk("rsp_result", 32'(rsp_result), 32'(m_res));
        chk("rsp_status", 32'(rsp_status), 32'(m_stat));
        chk("exe_oper",   32'(exe_oper),   32'(m_oper));
        chk("exe_argA",   32'(exe_a),      32'(m_a));
        chk("exe_argB",   32'(exe_b),      32'(m_b));
        for (int i = 0; i < int'(REQ); i++) if (req_ready[i]) grant_log.push_back(i);
        if (rsp_valid) rv_cycles++;
        if (rsp_valid && rsp_ready) begin
            rsp_ids.push_back(int'(rsp_id));
            rsp_cycles.push_back(cyc);
        end
        last_ready = req_ready;
        cyc++;
    end

    // Advance one cycle; accepted requesters drop valid unless holding continuously.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold) req_valid = req_valid & ~last_ready;
    endtask

    initial begin
        int g0, r0, n_rsp;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req_valid = '0; req_oper = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_exe_argA", 32'(exe_a), 32'd0);
        tick();
        rst = 1'b0;

        // Single op from requester 2.
        req_oper[2] = OP_1; req_a[2] = 4'd3; req_b[2] = 4'd5; req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b0100);
        tick(); tick(); tick();
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id), 32'd2);
        chk("t1_rsp_result", 32'(rsp_result), 32'd6);
        chk("t1_rsp_status", 32'(rsp_status), 32'b0101);
        tick();

        // Pointer now 3: requester 3 beats requester 0.
        req_oper[0] = OP_2; req_a[0] = 4'h9; req_b[0] = 4'hC;
        req_oper[3] = OP_3; req_a[3] = 4'hF; req_b[3] = 4'h1;
        req_valid = 4'b1001;
        repeat (8) tick();
        chk("t3_grants", 32'(grant_log.size()), 32'd3);
        chk("t3_first", 32'(grant_log[1]), 32'd3);
        chk("t3_second", 32'(grant_log[2]), 32'd0);

        // Response backpressure for five RESP cycles.
        req_oper[1] = OP_0; req_a[1] = 4'd7; req_b[1] = 4'd2; req_valid = 4'b0010;
        rsp_ready = 1'b0; rv_cycles = 0;
        repeat (5) tick();
        @(negedge clk);
        chk("t4_result", 32'(rsp_result), 32'd5);
        chk("t4_status", 32'(rsp_status), 32'b0001);
        chk("t4_ready", 32'(req_ready), 32'd0);
        repeat (3) tick();
        rsp_ready = 1'b1;
        tick();
        chk("t4_rv_cycles", 32'(rv_cycles), 32'd6);

        // Reset during CAPT drops the op.
        req_oper[2] = OP_3; req_a[2] = 4'hA; req_b[2] = 4'h5; req_valid = 4'b0100;
        n_rsp = rsp_ids.size();
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_exe_oper", 32'(exe_oper), 32'd0);
        repeat (4) tick();
        chk("t5_no_rsp", 32'(rsp_ids.size()), 32'(n_rsp));

        // All four continuously valid from pointer 0.
        for (int i = 0; i < int'(REQ); i++) begin
            req_oper[i] = N'(i); req_a[i] = M'(i + 1); req_b[i] = M'(3 * i);
        end
        hold = 1'b1; req_valid = 4'b1111;
        g0 = grant_log.size(); r0 = rsp_cycles.size();
        repeat (17) tick();
        req_valid = '0; hold = 1'b0;
        repeat (4) tick();
        chk("t2_count", 32'(grant_log.size() - g0), 32'd5);
        for (int k = 0; k < 5; k++) chk("t2_order", 32'(grant_log[g0 + k]), 32'(exp_order[k]));
        for (int k = 1; k < 5; k++) chk("t2_spacing", 32'(rsp_cycles[r0 + k] - rsp_cycles[r0 + k - 1]), 32'd4);

        // Ten idle cycles leave the pointer at 1.
        repeat (10) begin
            tick();
            @(negedge clk);
            chk("t6_busy", 32'(busy), 32'd0);
            chk("t6_ready", 32'(req_ready), 32'd0);
        end
        tick();
        req_oper[0] = OP_1; req_a[0] = 4'd1; req_b[0] = 4'd1;
        req_oper[1] = OP_2; req_a[1] = 4'd6; req_b[1] = 4'd3;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("t6_ptr_grant", 32'(req_ready), 32'b0010);
        repeat (8) tick();
        chk("t6_last_id", 32'(rsp_ids[rsp_ids.size() - 1]), 32'd0);
        chk("t6_prev_id", 32'(rsp_ids[rsp_ids.size() - 2]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
